axis_read_addr: RTL and testbench
=================================

# axis_read_addr

Read-address controller that sequences a DRAM-to-stream transfer. It accepts a transfer request (start address, length in stream words) and forwards the length to the `axis_read_data` config port. It then splits the transfer into AXI4 INCR bursts on the AR channel, limits the number of outstanding bursts by monitoring R-channel `rlast` beats, and optionally keeps each burst inside a 4 KB page.

## Interface
- `CFG_AWIDTH`, 32: width of `cfg_address`
- `CFG_DWIDTH`, 32: width of `cfg_length` and `rd_length`
- `AXI_ADDR_WIDTH`, 32: width of `axi_araddr`
- `AXI_DATA_WIDTH`, 256: AXI data bus width (bits)
- `DATA_WIDTH`, 32: stream word width; `AXI_DATA_WIDTH/DATA_WIDTH` (WPB) is a power of two
- `AXI_LEN_WIDTH`, 8: width of `axi_arlen`
- `BURST_MAX`, 16: maximum beats per burst (1..2^AXI_LEN_WIDTH)
- `OUTSTANDING`, 4: maximum bursts issued without their `rlast`
- `clk`  in  1  clock; all logic on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `cfg_address`  in  CFG_AWIDTH  byte start address; low log2(AXI_DATA_WIDTH/8) bits are ignored (forced 0)
- `cfg_length`  in  CFG_DWIDTH  transfer length in DATA_WIDTH words
- `cfg_val` / `cfg_rdy`  in/out  1  request handshake
- `rd_length`  out  CFG_DWIDTH  length forwarded to `axis_read_data`
- `rd_val` / `rd_rdy`  out/in  1  forward handshake
- `axi_araddr`  out  AXI_ADDR_WIDTH  burst address
- `axi_arlen`  out  AXI_LEN_WIDTH  beats-1
- `axi_arsize`  out  3  constant log2(AXI_DATA_WIDTH/8)
- `axi_arburst`  out  2  constant 2'b01
- `axi_arvalid` / `axi_arready`  out/in  1  AR handshake
- `axi_rlast`, `axi_rvalid`, `axi_rready`  in  1  R-channel monitor only
- `busy`  out  1  high in every state except IDLE

## Operation
- States: IDLE, FWD, CALC, ADDR.
- IDLE:
  - `cfg_rdy`=1.
  - On `cfg_val`: latch the address and compute beats = ceil(cfg_length/WPB), with CFG_DWIDTH-bit arithmetic.
  - If `cfg_length`=0: drop the request and stay in IDLE.
  - Otherwise go to FWD.
- FWD: `rd_val`=1 and `rd_length`=the latched length; on `rd_rdy`, go to CALC.
- CALC:
  - burst = min(BURST_MAX, beats_left, beats_to_4K).
  - If outstanding < OUTSTANDING, go to ADDR; otherwise wait in CALC.
- ADDR:
  - Drive `axi_arvalid`=1; address, len, valid and burst stay stable until `axi_arready`.
  - On the handshake: address += burst·(AXI_DATA_WIDTH/8), beats_left -= burst.
  - Then go to IDLE if beats_left=0, else CALC.
- Outstanding counter:
  - +1 on an AR handshake.
  - −1 on `axi_rvalid & axi_rready & axi_rlast`.
  - Both in the same cycle: unchanged.
  - Never exceeds OUTSTANDING; never underflows (an rlast at 0 is ignored).
  - The counter persists across transfers, so a new request can be accepted while earlier bursts are still returning data.
- Address wraps modulo 2^AXI_ADDR_WIDTH.

## Timing
- Reset values: `cfg_rdy`, `rd_val`, `axi_arvalid`, `busy`, `rd_length`, `axi_araddr`, `axi_arlen` all 0; `axi_arsize`/`axi_arburst` constant.
- `cfg_rdy` is registered and rises on the first clock edge after `rst_n` deasserts.
- Request handshake at edge N: `rd_val` is high after N.
- `rd_rdy` handshake at edge M: CALC for one cycle, `axi_arvalid` high after M+1.
- After an AR handshake: the next burst's `axi_arvalid` asserts 2 edges later (CALC, then ADDR).
- After the last AR handshake: `cfg_rdy` is high after that edge.
- `rst_n` low mid-operation: all outputs drop immediately (asynchronous); state, counters and the request are discarded.

## Configuration
- `AXIS_READ_ADDR_4K_SPLIT_EN` defined: beats_to_4K = (4096 − address[11:0]) / (AXI_DATA_WIDTH/8), so no burst crosses a 4 KB boundary.
- Not defined: beats_to_4K is not used; burst = min(BURST_MAX, beats_left).

## Test plan
- Address 0x1000, length 10, `rd_rdy`/`axi_arready` held 1 → `rd_length`=10; one burst, `araddr`=0x1000, `arlen`=1, `arsize`=5; `cfg_rdy` returns.
- Address 0, length 4092 → 32 bursts, `arlen`=15, addresses 0x0, 0x200 … 0x3E00; the outstanding limit is exercised by a bench returning `rlast` after 16 beats.
- Address 0x0F80, length 64: with the macro defined → bursts (0x0F80, `arlen` 3) then (0x1000, `arlen` 3); without it → one burst (0x0F80, `arlen` 7).
- `axi_arready`=1, no `rlast`, OUTSTANDING=4, length 1024 → exactly 4 AR handshakes, then `axi_arvalid` stays 0; one `rlast` beat → exactly one more burst issues 2 cycles later.
- Length 0 → no `rd_val`, no `axi_arvalid`, `cfg_rdy` stays 1; `rd_rdy` held 0 → stays in FWD with `rd_val` held and no AR activity.
- `rst_n` pulsed low while `axi_arvalid`=1 → `axi_arvalid` falls the same instant, outstanding count cleared, `cfg_rdy` high after the first edge following release.

Source files
------------

// File: rtl/axis_read_addr.sv
// Read-address controller: forwards the transfer length, then splits the transfer into AXI4 INCR
// bursts with an outstanding-burst limit. Define AXIS_READ_ADDR_4K_SPLIT_EN to keep bursts inside 4 KB pages.
module axis_read_addr #(
  parameter int unsigned CFG_AWIDTH     = 32,
  parameter int unsigned CFG_DWIDTH     = 32,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 256,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned AXI_LEN_WIDTH  = 8,
  parameter int unsigned BURST_MAX      = 16,
  parameter int unsigned OUTSTANDING    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CFG_AWIDTH-1:0]     cfg_address,
  input  logic [CFG_DWIDTH-1:0]     cfg_length,
  input  logic                      cfg_val,
  output logic                      cfg_rdy,
  output logic [CFG_DWIDTH-1:0]     rd_length,
  output logic                      rd_val,
  input  logic                      rd_rdy,
  output logic [AXI_ADDR_WIDTH-1:0] axi_araddr,
  output logic [AXI_LEN_WIDTH-1:0]  axi_arlen,
  output logic [2:0]                axi_arsize,
  output logic [1:0]                axi_arburst,
  output logic                      axi_arvalid,
  input  logic                      axi_arready,
  input  logic                      axi_rlast,
  input  logic                      axi_rvalid,
  input  logic                      axi_rready,
  output logic                      busy
);

  localparam int unsigned BYTES     = AXI_DATA_WIDTH / 8;
  localparam int unsigned ARSIZE    = $clog2(BYTES);
  localparam int unsigned WPB       = AXI_DATA_WIDTH / DATA_WIDTH;
  localparam int unsigned WPB_SHIFT = $clog2(WPB);
  localparam int unsigned OUT_W     = $clog2(OUTSTANDING + 1);

  typedef enum logic [1:0] {S_IDLE, S_FWD, S_CALC, S_ADDR} state_t;

  state_t                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CFG_DWIDTH-1:0]     beats_left_q, beats_left_d;
  logic [CFG_DWIDTH-1:0]     burst_q, burst_d;
  logic [OUT_W-1:0]          out_cnt_q, out_cnt_d;
  logic                      cfg_rdy_q, cfg_rdy_d;
  logic                      rd_val_q, rd_val_d;
  logic [CFG_DWIDTH-1:0]     rd_length_q, rd_length_d;
  logic                      arvalid_q, arvalid_d;
  logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [AXI_LEN_WIDTH-1:0]  arlen_q, arlen_d;
  logic                      busy_q, busy_d;

  logic                      ar_hs_c;
  logic                      r_done_c;
  logic [CFG_DWIDTH-1:0]     burst_c;

  assign ar_hs_c  = arvalid_q & axi_arready;
  assign r_done_c = axi_rvalid & axi_rready & axi_rlast;

`ifdef AXIS_READ_ADDR_4K_SPLIT_EN
  logic [12:0]           page_rem_c;
  logic [CFG_DWIDTH-1:0] beats_to_4k_c;
  assign page_rem_c    = 13'd4096 - {1'b0, addr_q[11:0]};
  assign beats_to_4k_c = CFG_DWIDTH'(page_rem_c >> ARSIZE);
`endif

  // Size of the next burst from the remaining beats (and page room when splitting is enabled)
  always_comb begin
    burst_c = beats_left_q;
    if (burst_c > CFG_DWIDTH'(BURST_MAX)) burst_c = CFG_DWIDTH'(BURST_MAX);
`ifdef AXIS_READ_ADDR_4K_SPLIT_EN
    if (burst_c > beats_to_4k_c) burst_c = beats_to_4k_c;
`endif
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    beats_left_d = beats_left_q;
    burst_d      = burst_q;
    out_cnt_d    = out_cnt_q;
    rd_val_d     = rd_val_q;
    rd_length_d  = rd_length_q;
    arvalid_d    = arvalid_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;

    unique case (state_q)
      S_IDLE: begin
        if (cfg_val && cfg_rdy_q && (cfg_length != '0)) begin
          addr_d       = AXI_ADDR_WIDTH'(cfg_address) & ~AXI_ADDR_WIDTH'(BYTES - 1);
          rd_length_d  = cfg_length;
          beats_left_d = (cfg_length + CFG_DWIDTH'(WPB - 1)) >> WPB_SHIFT;
          rd_val_d     = 1'b1;
          state_d      = S_FWD;
        end
      end
      S_FWD: begin
        if (rd_rdy) begin
          rd_val_d = 1'b0;
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        burst_d = burst_c;
        if (out_cnt_q < OUT_W'(OUTSTANDING)) begin
          arvalid_d = 1'b1;
          araddr_d  = addr_q;
          arlen_d   = AXI_LEN_WIDTH'(burst_c - CFG_DWIDTH'(1));
          state_d   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (axi_arready) begin
          arvalid_d    = 1'b0;
          addr_d       = addr_q + (AXI_ADDR_WIDTH'(burst_q) << ARSIZE);
          beats_left_d = beats_left_q - burst_q;
          state_d      = (beats_left_q == burst_q) ? S_IDLE : S_CALC;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outstanding bursts: AR handshake adds one, an rlast beat retires one
    unique case ({ar_hs_c, r_done_c})
      2'b10:   if (out_cnt_q != OUT_W'(OUTSTANDING)) out_cnt_d = out_cnt_q + OUT_W'(1);
      2'b01:   if (out_cnt_q != '0) out_cnt_d = out_cnt_q - OUT_W'(1);
      default: out_cnt_d = out_cnt_q;
    endcase

    cfg_rdy_d = (state_d == S_IDLE);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      beats_left_q <= '0;
      burst_q      <= '0;
      out_cnt_q    <= '0;
      cfg_rdy_q    <= 1'b0;
      rd_val_q     <= 1'b0;
      rd_length_q  <= '0;
      arvalid_q    <= 1'b0;
      araddr_q     <= '0;
      arlen_q      <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      beats_left_q <= beats_left_d;
      burst_q      <= burst_d;
      out_cnt_q    <= out_cnt_d;
      cfg_rdy_q    <= cfg_rdy_d;
      rd_val_q     <= rd_val_d;
      rd_length_q  <= rd_length_d;
      arvalid_q    <= arvalid_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      busy_q       <= busy_d;
    end
  end

  assign cfg_rdy     = cfg_rdy_q;
  assign rd_val      = rd_val_q;
  assign rd_length   = rd_length_q;
  assign axi_arvalid = arvalid_q;
  assign axi_araddr  = araddr_q;
  assign axi_arlen   = arlen_q;
  assign busy        = busy_q;
  assign axi_arsize  = 3'(ARSIZE);
  assign axi_arburst = 2'b01;

endmodule

// File: tb/tb_axis_read_addr.sv
// Directed bench for axis_read_addr; expected values are hand-derived for the default parameters
// (32 B beats, 8 words per beat, BURST_MAX 16, OUTSTANDING 4).
module tb_axis_read_addr;

  logic        clk;
  logic        rst_n;
  logic [31:0] cfg_address;
  logic [31:0] cfg_length;
  logic        cfg_val;
  logic        cfg_rdy;
  logic [31:0] rd_length;
  logic        rd_val;
  logic        rd_rdy;
  logic [31:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;
  logic        axi_arvalid;
  logic        axi_arready;
  logic        axi_rlast;
  logic        axi_rvalid;
  logic        axi_rready;
  logic        busy;

  int n_checks = 0;
  int n_err    = 0;

  axis_read_addr dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_address(cfg_address), .cfg_length(cfg_length), .cfg_val(cfg_val), .cfg_rdy(cfg_rdy),
    .rd_length(rd_length), .rd_val(rd_val), .rd_rdy(rd_rdy),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rlast_pulse();
    axi_rvalid = 1'b1; axi_rready = 1'b1; axi_rlast = 1'b1;
    tick();
    axi_rvalid = 1'b0; axi_rready = 1'b0; axi_rlast = 1'b0;
  endtask

  initial begin
    int n_hs;
    int idx, pending, beat, maxp, cyc;
    bit done, hs_ar, hs_r;

    rst_n = 1'b1;
    cfg_address = '0; cfg_length = '0; cfg_val = 1'b0;
    rd_rdy = 1'b0; axi_arready = 1'b0;
    axi_rlast = 1'b0; axi_rvalid = 1'b0; axi_rready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_cfg_rdy", 64'(cfg_rdy), 64'd0);
    chk("rst_rd_val", 64'(rd_val), 64'd0);
    chk("rst_arvalid", 64'(axi_arvalid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rd_length", 64'(rd_length), 64'd0);
    chk("rst_araddr", 64'(axi_araddr), 64'd0);
    chk("rst_arlen", 64'(axi_arlen), 64'd0);
    chk("arsize", 64'(axi_arsize), 64'd5);
    chk("arburst", 64'(axi_arburst), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("cfg_rdy_before_edge", 64'(cfg_rdy), 64'd0);
    tick();
    chk("cfg_rdy_after_edge", 64'(cfg_rdy), 64'd1);

    // Single short burst: 10 words -> 2 beats
    cfg_address = 32'h1000; cfg_length = 32'd10; cfg_val = 1'b1;
    rd_rdy = 1'b1; axi_arready = 1'b1;
    tick();
    cfg_val = 1'b0;
    chk("a_rd_val", 64'(rd_val), 64'd1);
    chk("a_rd_length", 64'(rd_length), 64'd10);
    chk("a_cfg_rdy_low", 64'(cfg_rdy), 64'd0);
    chk("a_busy", 64'(busy), 64'd1);
    tick();
    chk("a_rd_val_drop", 64'(rd_val), 64'd0);
    chk("a_calc_no_ar", 64'(axi_arvalid), 64'd0);
    tick();
    chk("a_arvalid", 64'(axi_arvalid), 64'd1);
    chk("a_araddr", 64'(axi_araddr), 64'h1000);
    chk("a_arlen", 64'(axi_arlen), 64'd1);
    tick();
    chk("a_arvalid_done", 64'(axi_arvalid), 64'd0);
    chk("a_cfg_rdy_back", 64'(cfg_rdy), 64'd1);
    chk("a_busy_done", 64'(busy), 64'd0);

    // Zero-length request is dropped
    cfg_length = 32'd0; cfg_val = 1'b1;
    tick();
    cfg_val = 1'b0;
    chk("z_cfg_rdy", 64'(cfg_rdy), 64'd1);
    chk("z_rd_val", 64'(rd_val), 64'd0);
    chk("z_busy", 64'(busy), 64'd0);
    tick();
    chk("z_arvalid", 64'(axi_arvalid), 64'd0);
    chk("z_rd_val2", 64'(rd_val), 64'd0);

    // 64 words at 0xF80: 8 beats, 4 beats of room before the page boundary
    cfg_address = 32'h0F80; cfg_length = 32'd64; cfg_val = 1'b1;
    tick();
    cfg_val = 1'b0;
    chk("p_rd_length", 64'(rd_length), 64'd64);
    tick();
    tick();
    chk("p_arvalid0", 64'(axi_arvalid), 64'd1);
    chk("p_araddr0", 64'(axi_araddr), 64'h0F80);
`ifdef AXIS_READ_ADDR_4K_SPLIT_EN
    chk("p_arlen0", 64'(axi_arlen), 64'd3);
    tick();
    chk("p_gap", 64'(axi_arvalid), 64'd0);
    chk("p_busy_mid", 64'(busy), 64'd1);
    tick();
    chk("p_arvalid1", 64'(axi_arvalid), 64'd1);
    chk("p_araddr1", 64'(axi_araddr), 64'h1000);
    chk("p_arlen1", 64'(axi_arlen), 64'd3);
    tick();
    chk("p_cfg_rdy", 64'(cfg_rdy), 64'd1);
`else
    chk("p_arlen0", 64'(axi_arlen), 64'd7);
    tick();
    chk("p_arvalid_done", 64'(axi_arvalid), 64'd0);
    chk("p_cfg_rdy", 64'(cfg_rdy), 64'd1);
`endif

    // Retire all earlier bursts; surplus rlast beats at zero must be ignored
    repeat (4) rlast_pulse();

    // rd_rdy held low keeps the request in FWD
    rd_rdy = 1'b0;
    cfg_address = 32'h2000; cfg_length = 32'd1024; cfg_val = 1'b1;
    tick();
    cfg_val = 1'b0;
    repeat (3) tick();
    chk("f_rd_val_held", 64'(rd_val), 64'd1);
    chk("f_no_ar", 64'(axi_arvalid), 64'd0);
    chk("f_busy", 64'(busy), 64'd1);

    // 128 beats, no rlast returned: only OUTSTANDING bursts may issue
    rd_rdy = 1'b1;
    n_hs = 0;
    for (int i = 0; i < 30; i++) begin
      if (axi_arvalid && axi_arready) n_hs++;
      tick();
    end
    chk("l_handshakes", 64'(n_hs), 64'd4);
    chk("l_arvalid_idle", 64'(axi_arvalid), 64'd0);
    chk("l_busy", 64'(busy), 64'd1);
    rlast_pulse();
    chk("l_release_gap", 64'(axi_arvalid), 64'd0);
    tick();
    chk("l_release_arvalid", 64'(axi_arvalid), 64'd1);
    chk("l_release_araddr", 64'(axi_araddr), 64'h2800);
    chk("l_release_arlen", 64'(axi_arlen), 64'd15);
    n_hs = 0;
    for (int i = 0; i < 10; i++) begin
      if (axi_arvalid && axi_arready) n_hs++;
      tick();
    end
    chk("l_one_more", 64'(n_hs), 64'd1);

    // Reset while an AR is pending
    axi_arready = 1'b0;
    rlast_pulse();
    tick();
    chk("r_arvalid_pending", 64'(axi_arvalid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("r_arvalid_drop", 64'(axi_arvalid), 64'd0);
    chk("r_busy_drop", 64'(busy), 64'd0);
    chk("r_cfg_rdy_drop", 64'(cfg_rdy), 64'd0);
    chk("r_araddr_drop", 64'(axi_araddr), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("r_cfg_rdy_low", 64'(cfg_rdy), 64'd0);
    tick();
    chk("r_cfg_rdy_high", 64'(cfg_rdy), 64'd1);

    // 4092 words -> 512 beats -> 32 bursts of 16; R side returns rlast every 16 beats
    axi_arready = 1'b1; rd_rdy = 1'b1;
    cfg_address = 32'h0; cfg_length = 32'd4092; cfg_val = 1'b1;
    tick();
    cfg_val = 1'b0;
    idx = 0; pending = 0; beat = 0; maxp = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 3000) begin
      axi_rvalid = (pending > 0);
      axi_rready = 1'b1;
      axi_rlast  = (pending > 0) && (beat == 15);
      hs_ar = axi_arvalid && axi_arready;
      hs_r  = axi_rvalid && axi_rlast;
      if (hs_ar) begin
        chk("b_araddr", 64'(axi_araddr), 64'(idx * 512));
        chk("b_arlen", 64'(axi_arlen), 64'd15);
        idx++;
      end
      tick();
      cyc++;
      if (hs_ar) pending++;
      if (hs_r) pending--;
      if (axi_rvalid) beat = (beat + 1) % 16;
      if (pending > maxp) maxp = pending;
      if (idx == 32 && pending == 0) done = 1'b1;
    end
    axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_rready = 1'b0;
    chk("b_completed", 64'(done), 64'd1);
    chk("b_burst_count", 64'(idx), 64'd32);
    chk("b_max_outstanding", 64'(maxp), 64'd4);
    chk("b_cfg_rdy", 64'(cfg_rdy), 64'd1);
    chk("b_busy", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
